// File: rtl/word_align_pkg.sv
// Shared state encoding and default constants for the word aligner.
package word_align_pkg;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  localparam int          DEF_WIDTH      = 16;
  localparam int          DEF_DIST_WIDTH = 4;
  localparam logic [15:0] DEF_SYNC_WORD  = 16'hF628;
  localparam int          DEF_FRAME_LEN  = 8;
  localparam int          DEF_LOCK_CNT   = 3;
  localparam int          DEF_UNLOCK_CNT = 4;
endpackage

// File: rtl/align_rotate.sv
// Combinational barrel rotate-right of one word by a variable distance.
module align_rotate
  import word_align_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DIST_WIDTH = DEF_DIST_WIDTH
) (
  input  logic [WIDTH-1:0]      din,
  input  logic [DIST_WIDTH-1:0] distance,
  output logic [WIDTH-1:0]      dout
);
  assign dout = WIDTH'({din, din} >> distance);
endmodule

// File: rtl/word_align_hunt.sv
// Sync-word hunter: slips the rotate distance until SYNC_WORD is framed, then verifies/locks.
// Optional WORD_ALIGN_STATS_EN adds a saturating slip counter output.
module word_align_hunt
  import word_align_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               DIST_WIDTH = DEF_DIST_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(DEF_SYNC_WORD),
  parameter int               FRAME_LEN  = DEF_FRAME_LEN,
  parameter int               LOCK_CNT   = DEF_LOCK_CNT,
  parameter int               UNLOCK_CNT = DEF_UNLOCK_CNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic [DIST_WIDTH-1:0] distance,
  output logic                  locked,
  output logic                  sof
`ifdef WORD_ALIGN_STATS_EN
  ,output logic [15:0]          slip_count
`endif
);
  localparam int                FCNT_W    = $clog2(FRAME_LEN);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);
  localparam logic [3:0]        LOCK_C    = 4'(LOCK_CNT);
  localparam logic [3:0]        UNLOCK_C  = 4'(UNLOCK_CNT);

  state_e                state, state_n;
  logic [DIST_WIDTH-1:0] dist_n;
  logic [FCNT_W-1:0]     fcnt, fcnt_n;
  logic [3:0]            hits, hits_n, misses, misses_n;
  logic [WIDTH-1:0]      rot;
  logic                  match, slot, slip, sof_n;

  align_rotate #(.WIDTH(WIDTH), .DIST_WIDTH(DIST_WIDTH)) u_rot (
    .din      (din),
    .distance (distance),
    .dout     (rot)
  );

  assign match  = din_valid && (rot == SYNC_WORD);
  assign slot   = (fcnt == '0);
  assign locked = (state == LOCKED);

  always_comb begin
    state_n  = state;
    dist_n   = distance;
    fcnt_n   = fcnt;
    hits_n   = hits;
    misses_n = misses;
    slip     = 1'b0;
    sof_n    = 1'b0;
    if (din_valid) begin
      fcnt_n = (fcnt == FCNT_LAST) ? '0 : fcnt + 1'b1;
      unique case (state)
        HUNT: begin
          if (match) begin
            // Matched word is treated as slot 0, so the next word is slot 1.
            state_n  = VERIFY;
            hits_n   = 4'd1;
            misses_n = '0;
            fcnt_n   = FCNT_W'(1);
          end else begin
            slip = 1'b1;
          end
        end
        VERIFY: begin
          if (slot) begin
            if (match) begin
              if (hits + 4'd1 == LOCK_C) begin
                state_n  = LOCKED;
                hits_n   = '0;
                misses_n = '0;
                sof_n    = 1'b1;
              end else begin
                hits_n = hits + 4'd1;
              end
            end else begin
              state_n  = HUNT;
              hits_n   = '0;
              misses_n = '0;
              slip     = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (slot) begin
            if (match) begin
              misses_n = '0;
              sof_n    = 1'b1;
            end else if (misses + 4'd1 == UNLOCK_C) begin
              // Lock loss keeps the last good distance as the first guess.
              state_n  = HUNT;
              hits_n   = '0;
              misses_n = '0;
            end else begin
              misses_n = misses + 4'd1;
            end
          end
        end
        default: state_n = HUNT;
      endcase
      if (slip) dist_n = distance + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      distance   <= '0;
      fcnt       <= '0;
      hits       <= '0;
      misses     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
    end else begin
      state      <= state_n;
      distance   <= dist_n;
      fcnt       <= fcnt_n;
      hits       <= hits_n;
      misses     <= misses_n;
      if (din_valid) dout <= rot;
      dout_valid <= din_valid;
      sof        <= sof_n;
    end
  end

`ifdef WORD_ALIGN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                                slip_count <= '0;
    else if (slip && slip_count != 16'hFFFF) slip_count <= slip_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_word_align_hunt.sv
// Directed bench for word_align_hunt with a per-word behavioural model and per-cycle compare.
module tb_word_align_hunt;
  localparam int          W    = 16;
  localparam int          FL   = 8;
  localparam int          LC   = 3;
  localparam int          UC   = 4;
  localparam logic [15:0] SYNC = 16'hF628;
  localparam logic [15:0] ROT3 = 16'hB147;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic [3:0]  distance;
  logic        locked;
  logic        sof;
`ifdef WORD_ALIGN_STATS_EN
  logic [15:0] slip_count;
`endif

  word_align_hunt dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .distance   (distance),
    .locked     (locked),
    .sof        (sof)
`ifdef WORD_ALIGN_STATS_EN
    ,.slip_count (slip_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: mode 0=hunting, 1=verifying, 2=locked
  int          m_mode, m_dist, m_fcnt, m_hits, m_miss, m_slips;
  logic [15:0] e_dout;
  logic        e_dv, e_sof;

  function automatic logic [15:0] rotr(input logic [15:0] x, input int n);
    logic [15:0] r;
    for (int i = 0; i < W; i++) r[i] = x[(i + n) % W];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_slip();
    m_dist = (m_dist + 1) % W;
    if (m_slips < 65535) m_slips++;
  endtask

  task automatic model_step(input logic [15:0] d, input logic v, input logic r);
    logic [15:0] rw;
    bit          hit, in_slot;
    if (r) begin
      m_mode = 0; m_dist = 0; m_fcnt = 0; m_hits = 0; m_miss = 0; m_slips = 0;
      e_dout = '0; e_dv = 1'b0; e_sof = 1'b0;
      return;
    end
    e_dv  = v;
    e_sof = 1'b0;
    if (!v) return;
    rw      = rotr(d, m_dist);
    e_dout  = rw;
    hit     = (rw == SYNC);
    in_slot = (m_fcnt == 0);
    m_fcnt  = (m_fcnt + 1) % FL;
    case (m_mode)
      0: if (hit) begin m_mode = 1; m_hits = 1; m_miss = 0; m_fcnt = 1; end
         else do_slip();
      1: if (in_slot) begin
           if (hit) begin
             m_hits++;
             if (m_hits == LC) begin m_mode = 2; m_hits = 0; m_miss = 0; e_sof = 1'b1; end
           end else begin
             m_mode = 0; m_hits = 0; m_miss = 0; do_slip();
           end
         end
      default: if (in_slot) begin
           if (hit) begin m_miss = 0; e_sof = 1'b1; end
           else begin
             m_miss++;
             if (m_miss == UC) begin m_mode = 0; m_miss = 0; m_hits = 0; end
           end
         end
    endcase
  endtask

  task automatic drive(input logic [15:0] d, input logic v, input logic r);
    din = d; din_valid = v; rst = r;
    @(posedge clk);
    model_step(d, v, r);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("dout", 32'(dout), 32'(e_dout));
      check("dout_valid", 32'(dout_valid), 32'(e_dv));
      check("distance", 32'(distance), 32'(m_dist));
      check("locked", 32'(locked), 32'(m_mode == 2));
      check("sof", 32'(sof), 32'(e_sof));
`ifdef WORD_ALIGN_STATS_EN
      check("slip_count", 32'(slip_count), 32'(m_slips));
`endif
    end
  end

  task automatic send_frame(input bit bad_slot);
    drive(bad_slot ? 16'h0000 : ROT3, 1'b1, 1'b0);
    for (int i = 1; i < FL; i++) drive(ROT3, 1'b1, 1'b0);
  endtask

  initial begin
    drive(16'h0, 1'b0, 1'b1);
    drive(16'h0, 1'b1, 1'b1);
    chk_en = 1'b1;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_dv", 32'(dout_valid), 32'h0);
    check("rst_distance", 32'(distance), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_sof", 32'(sof), 32'h0);
    drive(16'h0, 1'b0, 1'b0);

    // Rotated-by-3 stream: three slips, match at word 3, lock on word 19
    for (int i = 0; i < 20; i++) begin
      drive(ROT3, 1'b1, 1'b0);
      if (i == 2) check("s031_dist_w2", 32'(distance), 32'd3);
      if (i == 3) check("s031_dout_w3", 32'(dout), 32'(SYNC));
      if (i == 18) check("s031_unlocked_w18", 32'(locked), 32'd0);
    end
    check("s031_locked", 32'(locked), 32'd1);
    check("s031_sof", 32'(sof), 32'd1);
    check("s031_model_dist", 32'(m_dist), 32'd3);
`ifdef WORD_ALIGN_STATS_EN
    check("s031_slip_count", 32'(slip_count), 32'd3);
`endif

    // Three corrupted slots then a good one: lock holds
    for (int i = 0; i < FL - 1; i++) drive(ROT3, 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) send_frame(1'b1);
    check("s032_hold3", 32'(locked), 32'd1);
    send_frame(1'b0);
    check("s032_hold_good", 32'(locked), 32'd1);
    for (int f = 0; f < 3; f++) send_frame(1'b1);
    check("s032_hold_miss3", 32'(locked), 32'd1);
    drive(16'h0000, 1'b1, 1'b0);
    check("s032_unlock", 32'(locked), 32'd0);
    check("s032_dist", 32'(distance), 32'd3);

    // Re-match immediately, then miss at the second sync slot
    for (int i = 0; i < FL; i++) begin
      drive(ROT3, 1'b1, 1'b0);
      check("s033_no_sof", 32'(sof), 32'd0);
    end
    drive(16'h0000, 1'b1, 1'b0);
    check("s033_dist4", 32'(distance), 32'd4);
    check("s033_no_sof_miss", 32'(sof), 32'd0);
    check("s033_unlocked", 32'(locked), 32'd0);

    // din_valid toggling during hunt
    drive(16'h0, 1'b0, 1'b1);
    drive(16'h0, 1'b1, 1'b0); check("s034_dv1", 32'(dout_valid), 32'd1);
    drive(16'h0, 1'b0, 1'b0); check("s034_dv0", 32'(dout_valid), 32'd0);
    drive(16'h0, 1'b1, 1'b0); check("s034_dv1b", 32'(dout_valid), 32'd1);
    drive(16'h0, 1'b0, 1'b0); check("s034_dv0b", 32'(dout_valid), 32'd0);
    check("s034_dist2", 32'(distance), 32'd2);

    // Distance wrap from 15 to 0, then lock on unrotated sync
    drive(16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) drive(16'h0, 1'b1, 1'b0);
    check("s035_dist15", 32'(distance), 32'd15);
    drive(SYNC, 1'b1, 1'b0);
    check("s035_wrap0", 32'(distance), 32'd0);
    for (int i = 0; i < 17; i++) drive(SYNC, 1'b1, 1'b0);
    check("s035_locked", 32'(locked), 32'd1);
    check("s035_sof", 32'(sof), 32'd1);
    drive(SYNC, 1'b1, 1'b1);
    check("s035_rst_locked", 32'(locked), 32'd0);
    check("s035_rst_dout", 32'(dout), 32'd0);
    check("s035_rst_dv", 32'(dout_valid), 32'd0);
    check("s035_rst_sof", 32'(sof), 32'd0);
    check("s035_rst_dist", 32'(distance), 32'd0);

`ifdef WORD_ALIGN_STATS_EN
    for (int i = 0; i < 70000; i++) drive(16'h0, 1'b1, 1'b0);
    check("s036_sat", 32'(slip_count), 32'hFFFF);
`endif

    drive(16'h0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/word_align_hunt.md
WORD_ALIGN_HUNT -- requirements
Module: word_align_hunt

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data word width; it SHALL be a power of two, at least 4.
REQ-002 SHALL have parameter DIST_WIDTH, default 4, equal to log2(WIDTH), giving the rotate-distance width.
REQ-003 SHALL have parameter SYNC_WORD, default 16'hF628, giving the aligned sync pattern.
REQ-004 SHALL have parameter FRAME_LEN, default 8, giving valid words per frame, with the sync word at slot 0; range 2..256.
REQ-005 SHALL have parameter LOCK_CNT, default 3, giving consecutive sync matches required to lock; range 2..15.
REQ-006 SHALL have parameter UNLOCK_CNT, default 4, giving consecutive sync misses required to drop lock; range 1..15.
REQ-007 SHALL have clock clk, input, 1 bit; single clock domain, rising edge.
REQ-008 SHALL have reset rst, input, 1 bit; synchronous and active-high.
REQ-009 SHALL have din, input, WIDTH bits: the unaligned input word.
REQ-010 SHALL have din_valid, input, 1 bit: din qualifier.
REQ-011 SHALL have dout, output, WIDTH bits: din rotated right by distance, registered.
REQ-012 SHALL have dout_valid, output, 1 bit: dout qualifier.
REQ-013 SHALL have distance, output, DIST_WIDTH bits: the current rotate distance, a feed for downstream rotators.
REQ-014 SHALL have locked, output, 1 bit: high while in LOCKED.
REQ-015 SHALL have sof, output, 1 bit: start-of-frame, qualified by dout_valid.

Function
REQ-016 SHALL compute dout = rotate-right(din, distance) and register it with din_valid, so latency is 1 cycle; dout holds its value when din_valid=0.
REQ-017 SHALL define a match as rotate-right(din, distance) == SYNC_WORD on a cycle with din_valid=1; cycles with din_valid=0 change no state, counter or distance.
REQ-018 SHALL define a slip as distance <= distance+1 modulo WIDTH, wrapping from WIDTH-1 to 0; a slip takes effect on the next valid word.
REQ-019 SHALL keep a frame counter fcnt that advances once per valid word and wraps from FRAME_LEN-1 to 0; a word is in the sync slot when fcnt==0.
REQ-020 SHALL, in HUNT, test every valid word: on a match go to VERIFY with hits=1 and fcnt=1; on a miss perform a slip.
REQ-021 SHALL, in VERIFY, test only sync-slot words: on a match increment hits, and go to LOCKED when hits reaches LOCK_CNT; on a miss go to HUNT and slip.
REQ-022 SHALL, in LOCKED, test only sync-slot words: on a match clear misses; on a miss increment misses, and go to HUNT with distance unchanged when misses reaches UNLOCK_CNT.
REQ-023 SHALL update locked in the same register update as the state transition, so locked rises in the cycle after the LOCK_CNT-th match.
REQ-024 SHALL assert sof together with dout_valid for a word that matched in a sync slot while in LOCKED, including the word that causes entry to LOCKED.
REQ-025 SHALL clear hits and misses on every state entry.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set state=HUNT, distance=0, fcnt=0, hits=0, misses=0, dout=0, dout_valid=0, locked=0 and sof=0, regardless of din_valid; reset mid-lock drops lock on the next edge.

Configuration
REQ-027 SHALL, when macro WORD_ALIGN_STATS_EN is defined, add output slip_count, 16 bits: a saturating count of slips (it holds at 16'hFFFF), reset to 0.
REQ-028 SHALL, when WORD_ALIGN_STATS_EN is not defined, omit the slip_count port and its logic; all other behaviour is identical.

Structure
REQ-029 SHALL place the state enum (HUNT, VERIFY, LOCKED) and the default parameter constants in the shared package word_align_pkg.
REQ-030 SHALL use one combinational sub-module, align_rotate (ports din, distance, dout), which computes the rotate-right as {din,din} >> distance.

Verification
REQ-031 SHALL cover this case: a continuous stream of 16'hB147 (SYNC_WORD rotated left by 3) -> slips on words 0-2, distance=3, match on word 3, slot matches on words 11 and 19, locked=1 the cycle after word 19, and dout=16'hF628 from word 3 onward.
REQ-032 SHALL cover this case: while locked, corrupt 4 consecutive sync slots -> locked falls after the 4th miss with distance still 3; corrupting only 3 slots, then a good one, keeps lock.
REQ-033 SHALL cover this case: a VERIFY miss at the second sync slot -> HUNT, distance=4 on the next valid word, and sof never asserted.
REQ-034 SHALL cover this case: din_valid toggling 1,0,1,0 during hunt -> slips and fcnt advance only on valid cycles, and dout_valid follows din_valid with 1-cycle delay.
REQ-035 SHALL cover this case: sync rotated by 0 with distance at 15 -> the slip wraps to 0 and the match then proceeds; asserting rst while locked -> all outputs 0 on the next edge.
REQ-036 SHALL cover this case: with WORD_ALIGN_STATS_EN defined, the REQ-031 stream gives slip_count=3; with 70000 forced slips, slip_count=16'hFFFF.
